// File: rtl/mul_seq.sv
// ============================================================================
//  Module   : mul_seq
//  Purpose  : Multi-cycle signed WIDTH x WIDTH multiplier (shift-and-add, one
//             multiplier bit per clock) with valid/ready handshakes. Returns
//             the low WIDTH bits of the product. Define MUL_OVF_EN to add the
//             ovf output flagging products that do not fit in WIDTH bits.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product
`ifdef MUL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int ACC_W = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [ACC_W-1:0] acc_q,     acc_d;
  logic [ACC_W-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplier_q,  mplier_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0] product_q, product_d;

  logic             w_last;
  logic [ACC_W-1:0] w_addend;
  logic [ACC_W-1:0] w_sum;

  // The MSB of b carries weight -2^(WIDTH-1), so the final step subtracts.
  assign w_last   = (cnt_q == LAST_CNT);
  assign w_addend = mplier_q[0] ? (w_last ? -mcand_q : mcand_q) : '0;
  assign w_sum    = acc_q + w_addend;

`ifdef MUL_OVF_EN
  logic ovf_q, ovf_d;
  logic w_ovf;

  // Product fits in WIDTH signed bits only if the top WIDTH+1 bits agree.
  assign w_ovf = !((&w_sum[ACC_W-1:WIDTH-1]) || !(|w_sum[ACC_W-1:WIDTH-1]));
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef MUL_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{a[WIDTH-1]}}, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // Multiplicand shifts left and multiplier right, so bit i is always at [0].
        acc_d    = w_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (w_last) begin
          product_d = w_sum[WIDTH-1:0];
`ifdef MUL_OVF_EN
          ovf_d     = w_ovf;
`endif
          cnt_d     = '0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

`ifdef MUL_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign product   = product_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq.sv
// ============================================================================
//  Module   : tb_mul_seq
//  Purpose  : Scoreboard bench for mul_seq (WIDTH=16 directed, WIDTH=8 random).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, product16;
  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, product8;
`ifdef MUL_OVF_EN
  logic        ovf16, ovf8;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] q16_p[$];
  bit          q16_o[$];
  logic [7:0]  q8_p[$];
  bit          q8_o[$];

  always #5 clk = ~clk;

  mul_seq #(.WIDTH(16)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .product   (product16)
`ifdef MUL_OVF_EN
    ,
    .ovf       (ovf16)
`endif
  );

  mul_seq #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .product   (product8)
`ifdef MUL_OVF_EN
    ,
    .ovf       (ovf8)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on the 16-bit unit, hold the result `hold` cycles, then consume.
  task automatic run16(input logic [15:0] ta, input logic [15:0] tb_, input logic [15:0] ep,
                       input bit eo, input int hold, input bit early);
    int          cyc;
    int          low;
    bit          stable;
    logic [15:0] snap;
    logic [15:0] exp_p;
    bit          exp_o;
    check_eq("in_ready_before_issue16", 32'(in_ready16), 32'd1);
    a16 = ta; b16 = tb_; in_valid16 = 1'b1; out_ready16 = early;
    tick();
    in_valid16 = 1'b0;
    q16_p.push_back(ep);
    q16_o.push_back(eo);
    cyc = 0; low = 0;
    while (!out_valid16 && cyc < 64) begin
      if (!in_ready16) low++;
      tick();
      cyc++;
    end
    check_eq("latency16", 32'(cyc), 32'd16);
    snap = product16; stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      if (!in_ready16) low++;
      in_valid16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom);
      tick();
      if (product16 !== snap || out_valid16 !== 1'b1) stable = 1'b0;
    end
    in_valid16 = 1'b0;
    if (hold > 0) check_eq("backpressure_stable16", 32'(stable), 32'd1);
    if (q16_p.size() == 0) begin
      check_eq("scoreboard16_empty", 32'd1, 32'd0);
    end else begin
      exp_p = q16_p.pop_front();
      exp_o = q16_o.pop_front();
      check_eq("product16", 32'(product16), 32'(exp_p));
`ifdef MUL_OVF_EN
      check_eq("ovf16", 32'(ovf16), 32'(exp_o));
`else
      if (exp_o) low = low + 0;
`endif
    end
    if (!in_ready16) low++;
    out_ready16 = 1'b1;
    tick();
    out_ready16 = 1'b0;
    check_eq("in_ready_low_cycles16", 32'(low), 32'(17 + hold));
    check_eq("out_valid_after_consume16", 32'(out_valid16), 32'd0);
    check_eq("in_ready_after_consume16", 32'(in_ready16), 32'd1);
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] ep, input bit eo);
    int         cyc;
    logic [7:0] exp_p;
    bit         exp_o;
    a8 = ta; b8 = tb_; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    q8_p.push_back(ep);
    q8_o.push_back(eo);
    cyc = 0;
    while (!out_valid8 && cyc < 32) begin
      tick();
      cyc++;
    end
    check_eq("latency8", 32'(cyc), 32'd8);
    if (q8_p.size() == 0) begin
      check_eq("scoreboard8_empty", 32'd1, 32'd0);
    end else begin
      exp_p = q8_p.pop_front();
      exp_o = q8_o.pop_front();
      check_eq("product8", 32'(product8), 32'(exp_p));
`ifdef MUL_OVF_EN
      check_eq("ovf8", 32'(ovf8), 32'(exp_o));
`else
      if (exp_o) cyc = cyc + 0;
`endif
    end
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
  endtask

  // Watch for any stray out_valid on the 16-bit unit over n cycles.
  task automatic quiet16(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (out_valid16) seen = 1'b1;
      tick();
    end
    check_eq(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    int         fa, fb, full;
    rst = 1'b1;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0;
    in_valid8  = 1'b0; out_ready8  = 1'b0; a8  = '0; b8  = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_eq("reset_in_ready16", 32'(in_ready16), 32'd1);
    check_eq("reset_out_valid16", 32'(out_valid16), 32'd0);
    check_eq("reset_product16", 32'(product16), 32'd0);
    check_eq("reset_in_ready8", 32'(in_ready8), 32'd1);
    check_eq("reset_out_valid8", 32'(out_valid8), 32'd0);
`ifdef MUL_OVF_EN
    check_eq("reset_ovf16", 32'(ovf16), 32'd0);
`endif

    // Directed WIDTH=16 arithmetic cases.
    run16(16'd3,      16'd5,      16'd15,     1'b0, 0, 1'b0);
    run16(16'd5,      16'd3,      16'd15,     1'b0, 0, 1'b0);
    run16(16'hFFFF,   16'hFFFF,   16'h0001,   1'b0, 0, 1'b0);
    run16(16'hFFF9,   16'd6,      16'hFFD6,   1'b0, 0, 1'b0);
    run16(16'h7FFF,   16'd0,      16'h0000,   1'b0, 0, 1'b0);
    run16(16'h1234,   16'd1,      16'h1234,   1'b0, 0, 1'b0);
    run16(16'h8000,   16'hFFFF,   16'h8000,   1'b1, 0, 1'b0);
    run16(16'h7FFF,   16'h7FFF,   16'h0001,   1'b1, 0, 1'b0);
    run16(16'hFF00,   16'h0080,   16'h8000,   1'b0, 0, 1'b0);
    // Backpressure with in_valid noise, then out_ready held high through RUN.
    run16(16'h0010,   16'h0011,   16'h0110,   1'b0, 10, 1'b0);
    run16(16'hFFFD,   16'd9,      16'hFFE5,   1'b0, 0, 1'b1);

    // Reset on the fifth RUN cycle discards the operation.
    a16 = 16'd100; b16 = 16'd100; in_valid16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_run_in_ready16", 32'(in_ready16), 32'd1);
    check_eq("rst_run_out_valid16", 32'(out_valid16), 32'd0);
    check_eq("rst_run_product16", 32'(product16), 32'd0);
    quiet16("rst_run_no_out_valid16", 30);
    run16(16'd2, 16'd2, 16'd4, 1'b0, 0, 1'b0);

    // Reset wins over a simultaneous in_valid.
    a16 = 16'd5; b16 = 16'd5; in_valid16 = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid16 = 1'b0;
    check_eq("rst_inval_in_ready16", 32'(in_ready16), 32'd1);
    quiet16("rst_inval_no_out_valid16", 30);
    check_eq("rst_inval_product16", 32'(product16), 32'd0);

    // WIDTH=8 random pairs, each repeated with operands swapped.
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      fa = $signed(ra);
      fb = $signed(rb);
      full = fa * fb;
      run8(ra, rb, full[7:0], (full > 127) || (full < -128));
      run8(rb, ra, full[7:0], (full > 127) || (full < -128));
    end

    check_eq("scoreboard16_drained", 32'(q16_p.size()), 32'd0);
    check_eq("scoreboard8_drained", 32'(q8_p.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
